// File: rtl/display_capture.sv
// Reconstructs a 4-digit multiplexed display (AN/HEX/point/LE) into parallel frames.
// The inputs are registered once. A digit is captured after AN has been stable for
// SETTLE registered clocks. A frame is published once all four digits have been seen.
module display_capture #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AN,
  input  logic [3:0]  HEX,
  input  logic        point,
  input  logic        LE,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs,
  output logic        frame_valid,
  output logic        scan_err,
  output logic [7:0]  err_cnt,
  output logic        stale
);

  localparam logic [3:0]  SettleCnt  = 4'(SETTLE);
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  // Registered copies of the scanner inputs
  logic [3:0]  anR;
  logic [3:0]  hexR;
  logic        pointR;
  logic        leR;

  // Dwell tracking
  logic [3:0]  anPrev;
  logic [3:0]  dwell;
  logic [3:0]  dwellNext;
  logic        anChanged;
  logic        settled;

  // Decode and capture
  logic [3:0]  digitOh;
  logic        isIllegal;
  logic        capture;
  logic        frameDone;
  logic        scanErrNext;

  // Shadow frame under construction
  logic [15:0] shadowHex;
  logic [3:0]  shadowPt;
  logic [3:0]  shadowLe;
  logic [15:0] shadowHexNext;
  logic [3:0]  shadowPtNext;
  logic [3:0]  shadowLeNext;
  logic [3:0]  seen;
  logic [3:0]  seenNext;

  // Staleness timer
  logic [15:0] timer;
  logic [15:0] timerInc;

  // Input register stage; AN idles at blank out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anR    <= 4'hF;
      hexR   <= 4'h0;
      pointR <= 1'b0;
      leR    <= 1'b0;
    end else begin
      anR    <= AN;
      hexR   <= HEX;
      pointR <= point;
      leR    <= LE;
    end
  end

  // Dwell next-state. The settle event fires only on the edge where dwell arrives at
  // SETTLE, so a held pattern produces exactly one capture or error.
  always_comb begin
    anChanged = (anR != anPrev);
    dwellNext = dwell;
    if (anChanged) begin
      dwellNext = 4'd1;
    end else if (dwell >= SettleCnt) begin
      dwellNext = SettleCnt;
    end else begin
      dwellNext = dwell + 4'd1;
    end
    settled = (dwellNext == SettleCnt) && (anChanged || (dwell != SettleCnt));
  end

  // AN decode: legal one-hot-low digit, blank, or illegal
  always_comb begin
    digitOh   = 4'b0000;
    isIllegal = 1'b0;
    case (anR)
      4'hE:    digitOh = 4'b0001;
      4'hD:    digitOh = 4'b0010;
      4'hB:    digitOh = 4'b0100;
      4'h7:    digitOh = 4'b1000;
      4'hF:    digitOh = 4'b0000;
      default: isIllegal = 1'b1;
    endcase
  end

  // Capture, frame completion and the shadow slot writes
  always_comb begin
    capture       = settled && (digitOh != 4'b0000);
    scanErrNext   = settled && isIllegal;
    seenNext      = seen;
    shadowHexNext = shadowHex;
    shadowPtNext  = shadowPt;
    shadowLeNext  = shadowLe;
    if (capture) begin
      seenNext = seen | digitOh;
      for (int n = 0; n < 4; n++) begin
        if (digitOh[n]) begin
          shadowHexNext[4*n +: 4] = hexR;
          shadowPtNext[n]         = pointR;
          shadowLeNext[n]         = leR;
        end
      end
    end
    frameDone = capture && (seenNext == 4'b1111);
  end

  // Dwell counter and previous-AN register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anPrev <= 4'hF;
      dwell  <= 4'd0;
    end else begin
      anPrev <= anR;
      dwell  <= dwellNext;
    end
  end

  // Shadow frame, seen mask and the published frame outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadowHex   <= 16'h0000;
      shadowPt    <= 4'b0000;
      shadowLe    <= 4'b0000;
      seen        <= 4'b0000;
      hexs        <= 16'h0000;
      points      <= 4'b0000;
      LEs         <= 4'b0000;
      frame_valid <= 1'b0;
    end else begin
      shadowHex   <= shadowHexNext;
      shadowPt    <= shadowPtNext;
      shadowLe    <= shadowLeNext;
      frame_valid <= frameDone;
      if (frameDone) begin
        seen   <= 4'b0000;
        hexs   <= shadowHexNext;
        points <= shadowPtNext;
        LEs    <= shadowLeNext;
      end else begin
        seen   <= seenNext;
      end
    end
  end

  // Scan error pulse and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_err <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      scan_err <= scanErrNext;
      if (scanErrNext && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign timerInc = timer + 16'd1;

  // Frame-age timer. A frame completion wins over a simultaneous stale assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 16'd0;
      stale <= 1'b0;
    end else if (frameDone) begin
      timer <= 16'd0;
      stale <= 1'b0;
    end else if (timer != TimeoutCnt) begin
      timer <= timerInc;
      stale <= (timerInc == TimeoutCnt);
    end else begin
      stale <= 1'b1;
    end
  end

endmodule

// File: doc/display_capture.md
DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 2: consecutive clocks AN must hold before a digit is captured (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 65535: clocks without a completed frame before stale asserts (legal range 1..65535).
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port AN  input  4: active-low digit enable from the display scanner.
REQ-006 SHALL have port HEX  input  4: nibble for the currently enabled digit.
REQ-007 SHALL have port point  input  1: decimal point for the currently enabled digit.
REQ-008 SHALL have port LE  input  1: latch enable for the currently enabled digit.
REQ-009 SHALL have port hexs  output  16: reconstructed nibbles; digit n occupies bits [4n+3:4n].
REQ-010 SHALL have port points  output  4: reconstructed points; bit n = digit n.
REQ-011 SHALL have port LEs  output  4: reconstructed LE values; bit n = digit n.
REQ-012 SHALL have port frame_valid  output  1: one-clock pulse when hexs/points/LEs update.
REQ-013 SHALL have port scan_err  output  1: one-clock pulse per settled illegal AN pattern.
REQ-014 SHALL have port err_cnt  output  8: saturating count of scan_err pulses.
REQ-015 SHALL have port stale  output  1: high while no frame has completed within TIMEOUT clocks.

Function
REQ-016 SHALL register AN, HEX, point and LE once on entry; all further logic uses the registered copies, adding one clock of latency.
REQ-017 SHALL decode the registered AN as E->digit 0, D->1, B->2, 7->3, F->blank, and any other value->illegal.
REQ-018 SHALL keep a dwell counter that loads 1 when AN differs from its previous registered value, increments while AN is unchanged, and saturates at SETTLE.
REQ-019 SHALL capture a digit on the edge at which dwell reaches SETTLE and AN is legal and non-blank.
  - HEX, point and LE are written into shadow slot n.
  - seen[n] is set.
  - A capture occurs at most once per dwell.
REQ-020 SHALL overwrite shadow slot n with the latest capture when digit n is captured again before the frame completes.
REQ-021 SHALL complete a frame when a capture makes seen = 4'b1111.
  - On that same edge, hexs/points/LEs load the shadow contents, including the completing digit.
  - frame_valid is high for the following clock only.
  - seen is cleared to 0000.
REQ-022 SHALL hold hexs/points/LEs unchanged between frames.
REQ-023 SHALL ignore a blank AN (F): no capture, no error, and dwell counting continues.
REQ-024 SHALL pulse scan_err for one clock on the edge at which dwell reaches SETTLE for an illegal AN; a held illegal pattern produces exactly one pulse.
REQ-025 SHALL increment err_cnt on each scan_err pulse, saturating at 255 without wrap.
REQ-026 SHALL count clocks since the last frame completion (or since reset) in a 16-bit timer.
  - stale asserts when the timer reaches TIMEOUT.
  - The timer saturates at TIMEOUT.
  - A frame completion clears the timer and deasserts stale on the same edge.
REQ-027 SHALL give a frame completion priority over a stale assertion when both occur on the same edge.
REQ-028 SHALL NOT generate glitch captures: an AN value held for fewer than SETTLE registered clocks produces no capture and no error.

Reset
REQ-029 SHALL on rst_n low immediately (asynchronously) clear all of the following to 0:
  - hexs, points, LEs, frame_valid, scan_err, err_cnt, stale;
  - shadow slots, seen, the dwell counter and the timer.
  - Input registers reset to AN=F, HEX=0, point=0, LE=0.
REQ-030 SHALL discard any partially collected frame on reset mid-frame; the first frame after release requires all four digits to be captured again.

Verification
REQ-031 Full frame, SETTLE=2: hold each step 3 clocks — AN=E/HEX=3/point=1/LE=0, AN=D/HEX=A/point=0/LE=1, AN=B/HEX=5/point=0/LE=0, AN=7/HEX=C/point=1/LE=1 -> hexs=16'hC5A3, points=4'b1001, LEs=4'b1010, exactly one frame_valid pulse.
REQ-032 Repeat digit: sequence E/HEX=1, D/HEX=2, E/HEX=9, B/HEX=4, 7/HEX=6 -> hexs=16'h6429, one frame_valid pulse.
REQ-033 Glitch: AN=D held 1 clock within an E-B-7 scan, SETTLE=2 -> no capture of digit 1, no frame_valid, scan_err=0.
REQ-034 Illegal and blank:
  - AN=4'b1100 held 5 clocks -> exactly one scan_err pulse, err_cnt=1.
  - AN=F held 5 clocks -> no scan_err, err_cnt unchanged.
  - 300 settled illegal patterns -> err_cnt=255.
REQ-035 Timeout, TIMEOUT=100: after reset, no scan for 100 clocks -> stale=1; then a full frame -> stale=0 on the frame_valid edge.
REQ-036 Reset mid-frame: capture digits 0 and 1, pulse rst_n low, then capture digits 2 and 3 -> no frame_valid; hexs=0 until all four digits are recaptured.
